// File: rtl/bram_frame_reader.sv
// bram_frame_reader: streams one image frame out of a 1-cycle-latency pixel RAM as valid/ready pixels
//   clk_i/rst_i          : clock, asynchronous active-high reset
//   start_i              : one-cycle frame request, honoured only in IDLE
//   busy_o/done_o        : frame in progress / one-cycle completion pulse
//   ram_enable_o, write_enable_o, address_o, ram_rdata_i : RAM read port (never writes)
//   pixel_*              : output stream (data, valid, ready, sof/eol/eof markers)
module bram_frame_reader #(
  parameter int unsigned RAM_WIDTH     = 24,
  parameter int unsigned RAM_ADDR_BITS = 20,
  parameter int unsigned IMG_WIDTH     = 1024,
  parameter int unsigned IMG_HEIGHT    = 768
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     ram_enable_o,
  output logic                     write_enable_o,
  output logic [RAM_ADDR_BITS-1:0] address_o,
  input  logic [RAM_WIDTH-1:0]     ram_rdata_i,
  output logic [RAM_WIDTH-1:0]     pixel_data_o,
  output logic                     pixel_valid_o,
  input  logic                     pixel_ready_i,
  output logic                     pixel_sof_o,
  output logic                     pixel_eol_o,
  output logic                     pixel_eof_o
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam int unsigned NPIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int CW = IMG_WIDTH > 1 ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = IMG_HEIGHT > 1 ? $clog2(IMG_HEIGHT) : 1;
  localparam int FW = RAM_WIDTH + 3;

  logic [1:0]               state_q, state_d;
  logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [CW-1:0]            col_q, col_d;
  logic [RW-1:0]            row_q, row_d;
  logic [1:0]               inflight_q, inflight_d;
  logic [2:0]               count_q, count_d;
  logic [1:0]               rd_ptr_q, wr_ptr_q;
  logic                     rvalid_q;
  logic [2:0]               rflags_q;
  logic [FW-1:0]            mem_q [4];
  logic [FW-1:0]            head;
  logic                     issue, push, pop, last_col, last_row, last_addr;

  // Credit check uses registered occupancy only, so at most 4 entries can ever be owed to the FIFO.
  assign issue     = state_q == READ && (count_q + 3'(inflight_q)) < 3'd4;
  assign last_col  = col_q == CW'(IMG_WIDTH - 1);
  assign last_row  = row_q == RW'(IMG_HEIGHT - 1);
  assign last_addr = addr_q == RAM_ADDR_BITS'(NPIX - 1);
  assign push      = rvalid_q;
  assign pop       = pixel_valid_o && pixel_ready_i;
  assign head      = mem_q[rd_ptr_q];

  assign pixel_valid_o  = count_q != 3'd0;
  assign pixel_data_o   = pixel_valid_o ? head[RAM_WIDTH-1:0] : '0;
  assign pixel_sof_o    = pixel_valid_o && head[RAM_WIDTH];
  assign pixel_eol_o    = pixel_valid_o && head[RAM_WIDTH+1];
  assign pixel_eof_o    = pixel_valid_o && head[RAM_WIDTH+2];
  assign done_o         = state_q == DRAIN && count_q == 3'd0 && inflight_q == 2'd0;
  assign busy_o         = state_q != IDLE && !done_o;
  assign ram_enable_o   = issue;
  assign write_enable_o = 1'b0;
  assign address_o      = addr_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    col_d      = col_q;
    row_d      = row_q;
    if (state_q == IDLE && start_i) begin
      state_d = READ;
      addr_d  = '0;
      col_d   = '0;
      row_d   = '0;
    end
    if (issue) begin
      addr_d  = addr_q + RAM_ADDR_BITS'(1);
      col_d   = last_col ? '0 : col_q + CW'(1);
      row_d   = last_col ? row_q + RW'(1) : row_q;
      state_d = last_addr ? DRAIN : state_q;
    end
    if (done_o) state_d = IDLE;
    inflight_d = inflight_q + 2'(issue) - 2'(push);
    count_d    = count_q + 3'(push) - 3'(pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rvalid_q   <= 1'b0;
      rflags_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      col_q      <= col_d;
      row_q      <= row_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_q + 2'(pop);
      wr_ptr_q   <= wr_ptr_q + 2'(push);
      rvalid_q   <= issue;
      rflags_q   <= {last_col && last_row, last_col, addr_q == '0};
    end
  end

  // Storage needs no reset: the outputs are gated by the count, which is reset.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {rflags_q, ram_rdata_i};
  end
endmodule
